// File: rtl/qdec_pkg.sv
`default_nettype none
// ============================================================================
//  Package : qdec_pkg
//  Shared definitions for the quadrature step decoder.
//    - Decode FSM state encoding.
//    - Direction constants, matching the polarity of o_up_down.
//    - Step classification codes and the Gray-step lookup function.
//  Revision: 1.0  initial release
// ============================================================================
package qdec_pkg;

    // Decode FSM state encoding
    localparam int          c_ST_W              = 1;
    localparam logic [0:0]  c_ST_IDLE_UNPRIMED  = 1'b0;
    localparam logic [0:0]  c_ST_TRACK          = 1'b1;

    // Direction levels driven on o_up_down
    localparam logic        c_DIR_UP            = 1'b1;
    localparam logic        c_DIR_DOWN          = 1'b0;

    // Classification of a {previous, current} AB pair
    localparam logic [1:0]  c_STEP_NONE         = 2'd0;
    localparam logic [1:0]  c_STEP_UP           = 2'd1;
    localparam logic [1:0]  c_STEP_DOWN         = 2'd2;
    localparam logic [1:0]  c_STEP_ERR          = 2'd3;

    // AB is packed as {A, B}. Up cycle: 00 -> 01 -> 11 -> 10 -> 00.
    // Any pair where both bits flip is a lost step and is reported as an error.
    function automatic logic [1:0] qdec_step_dir(input logic [1:0] prev_ab,
                                                 input logic [1:0] curr_ab);
        logic [1:0] step;
        step = c_STEP_NONE;
        case ({prev_ab, curr_ab})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step = c_STEP_UP;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step = c_STEP_DOWN;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: step = c_STEP_ERR;
            default:                                step = c_STEP_NONE;
        endcase
        return step;
    endfunction

endpackage : qdec_pkg
`default_nettype wire

// File: rtl/qdec_sync_filter.sv
`default_nettype none
// ============================================================================
//  Module  : qdec_sync_filter
//  Two-flop synchroniser followed by a stability filter for one encoder phase.
//  A synchronised level is accepted once it has been seen on FILT_LEN+1
//  consecutive samples; shorter pulses are dropped without any indication.
//
//  Ports
//    i_clk     in   clock, rising edge
//    i_rst     in   asynchronous active-high reset
//    i_in      in   raw phase input, asynchronous to i_clk
//    o_level   out  accepted level, already reflecting this cycle's acceptance
//    o_accept  out  high in the cycle a stable run reaches FILT_LEN+1 samples
//    o_valid   out  an accepted level exists since reset
//
//  o_level / o_accept / o_valid are combinational views of the filter
//  decision so the decoder can register its outputs on the very edge the
//  level is accepted.
//  Revision: 1.0  initial release
// ============================================================================
module qdec_sync_filter #(
    parameter int FILT_LEN = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_in,
    output logic o_level,
    output logic o_accept,
    output logic o_valid
);

    localparam int             c_CW     = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN + 1);
    localparam logic [c_CW:0]  c_LAST   = (c_CW + 1)'(FILT_LEN);
    localparam logic [c_CW:0]  c_ONE    = (c_CW + 1)'(1);
    localparam logic           c_BYPASS = (FILT_LEN == 0);

    logic            r_meta;
    logic            r_sync;
    logic [1:0]      r_vld;      // marks r_sync as holding a real sample, not the reset value
    logic            r_have;     // a candidate run is in progress
    logic            r_cand;
    logic [c_CW-1:0] r_cnt;      // samples in the current run minus one, saturating
    logic            r_level;
    logic            r_lvl_vld;

    logic            w_new_run;
    logic            w_at_last;
    logic [c_CW:0]   w_cnt_ext;
    logic [c_CW:0]   w_cnt_inc;
    logic            w_accept;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_vld  <= 2'b00;
        end else begin
            r_meta <= i_in;
            r_sync <= r_meta;
            r_vld  <= {r_vld[0], 1'b1};
        end
    end

    assign w_new_run = !r_have || (r_sync != r_cand);
    assign w_cnt_ext = {1'b0, r_cnt};
    assign w_cnt_inc = w_cnt_ext + c_ONE;
    assign w_at_last = (w_cnt_ext == c_LAST);

    // Accept exactly once per stable run: on the sample that brings the run
    // length to FILT_LEN+1. With FILT_LEN = 0 the first sample of a run does it.
    always_comb begin
        w_accept = 1'b0;
        if (r_vld[1]) begin
            if (w_new_run) begin
                w_accept = c_BYPASS;
            end else begin
                w_accept = !w_at_last && (w_cnt_inc == c_LAST);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_have    <= 1'b0;
            r_cand    <= 1'b0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_lvl_vld <= 1'b0;
        end else if (r_vld[1]) begin
            if (w_new_run) begin
                r_have <= 1'b1;
                r_cand <= r_sync;
                r_cnt  <= '0;
            end else if (!w_at_last) begin
                r_cnt  <= w_cnt_inc[c_CW-1:0];
            end
            if (w_accept) begin
                r_level   <= r_sync;
                r_lvl_vld <= 1'b1;
            end
        end
    end

    assign o_accept = w_accept;
    assign o_level  = w_accept ? r_sync : r_level;
    assign o_valid  = r_lvl_vld || w_accept;

endmodule : qdec_sync_filter
`default_nettype wire

// File: rtl/quad_step_decoder.sv
`default_nettype none
// ============================================================================
//  Module  : quad_step_decoder
//  Quadrature A/B step decoder. Synchronises and filters both phases,
//  decodes Gray-code steps into a one-cycle count enable plus a direction
//  level, and flags lost steps (both phases changing together) in a sticky
//  error bit.
//
//  Ports
//    i_clk      in   clock, rising edge
//    i_rst      in   asynchronous active-high reset (release synchronous to i_clk)
//    i_a        in   encoder phase A, asynchronous
//    i_b        in   encoder phase B, asynchronous
//    i_clr_err  in   synchronous clear of o_err (a new error wins)
//    o_en       out  one-cycle pulse per valid step
//    o_up_down  out  direction of the last valid step, 1 = up
//    o_err      out  sticky illegal-transition flag
//    o_pos      out  [POS_W-1:0] wrapping position count (QDEC_POS_EN only)
//
//  Build option: define QDEC_POS_EN to add the o_pos port and its counter.
//  Latency: 3+FILT_LEN edges from the edge that first samples a new AB to o_en.
//  Revision: 1.0  initial release
// ============================================================================
module quad_step_decoder
    import qdec_pkg::*;
#(
    parameter int FILT_LEN = 2,
    parameter int POS_W    = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_a,
    input  logic             i_b,
    input  logic             i_clr_err,
    output logic             o_en,
    output logic             o_up_down,
    output logic             o_err
`ifdef QDEC_POS_EN
    ,
    output logic [POS_W-1:0] o_pos
`endif
);

    logic              w_a_level, w_a_acc, w_a_vld;
    logic              w_b_level, w_b_acc, w_b_vld;

    logic [c_ST_W-1:0] r_state, w_state_nxt;
    logic [1:0]        r_prev,  w_prev_nxt;
    logic              r_en,    w_en_nxt;
    logic              r_dir,   w_dir_nxt;
    logic              r_err,   w_err_nxt;
    logic              w_err_set;
    logic [1:0]        w_ab;
    logic [1:0]        w_step;

    qdec_sync_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_in     (i_a),
        .o_level  (w_a_level),
        .o_accept (w_a_acc),
        .o_valid  (w_a_vld)
    );

    qdec_sync_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_in     (i_b),
        .o_level  (w_b_level),
        .o_accept (w_b_acc),
        .o_valid  (w_b_vld)
    );

    assign w_ab   = {w_a_level, w_b_level};
    assign w_step = qdec_step_dir(r_prev, w_ab);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= c_ST_IDLE_UNPRIMED;
            r_prev  <= 2'b00;
            r_en    <= 1'b0;
            r_dir   <= c_DIR_DOWN;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_prev  <= w_prev_nxt;
            r_en    <= w_en_nxt;
            r_dir   <= w_dir_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_prev_nxt  = r_prev;
        w_en_nxt    = 1'b0;
        w_dir_nxt   = r_dir;
        w_err_set   = 1'b0;
        case (r_state)
            c_ST_IDLE_UNPRIMED: begin
                // Wait until both phases have a filtered level; that AB is
                // only a reference and never produces a step.
                if (w_a_vld && w_b_vld && (w_a_acc || w_b_acc)) begin
                    w_prev_nxt  = w_ab;
                    w_state_nxt = c_ST_TRACK;
                end
            end
            c_ST_TRACK: begin
                if (w_a_acc || w_b_acc) begin
                    case (w_step)
                        c_STEP_UP: begin
                            w_en_nxt   = 1'b1;
                            w_dir_nxt  = c_DIR_UP;
                            w_prev_nxt = w_ab;
                        end
                        c_STEP_DOWN: begin
                            w_en_nxt   = 1'b1;
                            w_dir_nxt  = c_DIR_DOWN;
                            w_prev_nxt = w_ab;
                        end
                        c_STEP_ERR: begin
                            // Resynchronise on the new AB so the next
                            // single-bit change decodes normally.
                            w_err_set  = 1'b1;
                            w_prev_nxt = w_ab;
                        end
                        default: ;
                    endcase
                end
            end
            default: w_state_nxt = c_ST_IDLE_UNPRIMED;
        endcase

        if (w_err_set) begin
            w_err_nxt = 1'b1;
        end else if (i_clr_err) begin
            w_err_nxt = 1'b0;
        end else begin
            w_err_nxt = r_err;
        end
    end

    assign o_en      = r_en;
    assign o_up_down = r_dir;
    assign o_err     = r_err;

`ifdef QDEC_POS_EN
    logic [POS_W-1:0] r_pos;

    // Updates on the same edge that raises o_en; wraps naturally.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pos <= '0;
        end else if (w_en_nxt) begin
            r_pos <= (w_dir_nxt == c_DIR_UP) ? (r_pos + POS_W'(1)) : (r_pos - POS_W'(1));
        end
    end

    assign o_pos = r_pos;
`endif

endmodule : quad_step_decoder
`default_nettype wire

// File: tb/tb_quad_step_decoder.sv
`default_nettype none
// ============================================================================
//  Module  : tb_quad_step_decoder
//  Self-checking bench for quad_step_decoder (FILT_LEN = 2, POS_W = 3).
//  A history-based reference model runs every cycle; a vector table and a
//  few hand-written sequences check step decoding, wrap, glitch rejection,
//  error stickiness and reset mid-step; a random phase walk follows.
//  o_pos is connected and checked when QDEC_POS_EN is defined.
//  Revision: 1.0  initial release
// ============================================================================
module tb_quad_step_decoder;

    localparam int c_FILT = 2;
    localparam int c_POSW = 3;
    localparam int c_LAT  = 3 + c_FILT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a = 1'b0, b = 1'b0, clr_err = 1'b0;
    logic en, up_down, err;
    logic [c_POSW-1:0] pos;

    int n_tests = 0;
    int n_fail  = 0;

    quad_step_decoder #(.FILT_LEN(c_FILT), .POS_W(c_POSW)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_a       (a),
        .i_b       (b),
        .i_clr_err (clr_err),
        .o_en      (en),
        .o_up_down (up_down),
        .o_err     (err)
`ifdef QDEC_POS_EN
        ,
        .o_pos     (pos)
`endif
    );

`ifndef QDEC_POS_EN
    assign pos = '0;
`endif

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [1:0]        hist[$];
    logic [1:0]        m_lvl  = 2'b00;
    logic [1:0]        m_lv   = 2'b00;
    logic              m_primed = 1'b0;
    logic [1:0]        m_prev = 2'b00;
    logic              exp_en = 1'b0, exp_dir = 1'b0, exp_err = 1'b0;
    logic [c_POSW-1:0] exp_pos = '0;

    function automatic int gpos(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        hist.delete();
        m_lvl = 2'b00; m_lv = 2'b00; m_primed = 1'b0; m_prev = 2'b00;
        exp_en = 1'b0; exp_dir = 1'b0; exp_err = 1'b0; exp_pos = '0;
    endtask

    // One rising edge: the filter sees the input sampled two edges earlier,
    // and accepts a value when that sample completes a run of exactly
    // FILT_LEN+1 equal samples.
    task automatic model_step();
        int sz, d;
        logic [1:0] acc, nab;
        logic s, ok, set;
        hist.push_back({a, b});
        if (hist.size() > 16) void'(hist.pop_front());
        sz = hist.size();
        acc = 2'b00;
        for (int ph = 0; ph < 2; ph++) begin
            if (sz >= 3 + c_FILT) begin
                s  = hist[sz-3][ph];
                ok = 1'b1;
                for (int j = 1; j <= c_FILT; j++)
                    if (hist[sz-3-j][ph] != s) ok = 1'b0;
                if (sz - 4 - c_FILT >= 0 && hist[sz-4-c_FILT][ph] == s) ok = 1'b0;
                if (ok) begin
                    acc[ph]   = 1'b1;
                    m_lvl[ph] = s;
                    m_lv[ph]  = 1'b1;
                end
            end
        end
        exp_en = 1'b0;
        set    = 1'b0;
        nab    = m_lvl;
        if (acc != 2'b00) begin
            if (!m_primed) begin
                if (m_lv == 2'b11) begin
                    m_primed = 1'b1;
                    m_prev   = nab;
                end
            end else begin
                d = (gpos(nab) - gpos(m_prev) + 4) % 4;
                if (d == 1) begin
                    exp_en = 1'b1; exp_dir = 1'b1; exp_pos = exp_pos + 1'b1; m_prev = nab;
                end else if (d == 3) begin
                    exp_en = 1'b1; exp_dir = 1'b0; exp_pos = exp_pos - 1'b1; m_prev = nab;
                end else if (d == 2) begin
                    set = 1'b1; m_prev = nab;
                end
            end
        end
        if (set) exp_err = 1'b1;
        else if (clr_err) exp_err = 1'b0;
    endtask

    // ---------------- checking helpers ----------------
    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
        cmp("model_outputs", {29'd0, en, up_down, err}, {29'd0, exp_en, exp_dir, exp_err});
`ifdef QDEC_POS_EN
        cmp("model_pos", {29'd0, pos}, {29'd0, exp_pos});
`endif
    endtask

    // Hold AB for n cycles; count pulses and record the first pulse latency.
    task automatic hold(input logic [1:0] ab, input int n, output int pulses, output int lat);
        {a, b} = ab;
        pulses = 0;
        lat    = -1;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (en === 1'b1) begin
                pulses++;
                if (lat < 0) lat = k;
            end
        end
    endtask

    typedef struct {
        logic [1:0]        ab;
        logic              clr;
        int                pulses;
        logic              dir;
        logic              err;
        logic [c_POSW-1:0] pos;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int p, l;
        // up run, down run with wrap, error jump, recovery, clear
        tbl[0]  = '{2'b01, 1'b0, 1, 1'b1, 1'b0, 3'd1};
        tbl[1]  = '{2'b11, 1'b0, 1, 1'b1, 1'b0, 3'd2};
        tbl[2]  = '{2'b10, 1'b0, 1, 1'b1, 1'b0, 3'd3};
        tbl[3]  = '{2'b00, 1'b0, 1, 1'b1, 1'b0, 3'd4};
        tbl[4]  = '{2'b10, 1'b0, 1, 1'b0, 1'b0, 3'd3};
        tbl[5]  = '{2'b11, 1'b0, 1, 1'b0, 1'b0, 3'd2};
        tbl[6]  = '{2'b01, 1'b0, 1, 1'b0, 1'b0, 3'd1};
        tbl[7]  = '{2'b00, 1'b0, 1, 1'b0, 1'b0, 3'd0};
        tbl[8]  = '{2'b10, 1'b0, 1, 1'b0, 1'b0, 3'd7};
        tbl[9]  = '{2'b00, 1'b0, 1, 1'b1, 1'b0, 3'd0};
        tbl[10] = '{2'b11, 1'b0, 0, 1'b1, 1'b1, 3'd0};
        tbl[11] = '{2'b10, 1'b0, 1, 1'b1, 1'b1, 3'd1};
        tbl[12] = '{2'b10, 1'b1, 0, 1'b1, 1'b0, 3'd1};

        // reset state
        model_reset();
        @(posedge clk); #1;
        cmp("reset_en",  {31'd0, en},      32'd0);
        cmp("reset_dir", {31'd0, up_down}, 32'd0);
        cmp("reset_err", {31'd0, err},     32'd0);
`ifdef QDEC_POS_EN
        cmp("reset_pos", {29'd0, pos},     32'd0);
`endif
        tick();
        rst = 1'b0;

        // priming on AB=00 produces nothing
        hold(2'b00, 20, p, l);
        cmp("prime_pulses", p, 0);
        cmp("prime_err", {31'd0, err}, 32'd0);

        // table of single steps
        for (int i = 0; i < 13; i++) begin
            {a, b}  = tbl[i].ab;
            clr_err = tbl[i].clr;
            tick();
            clr_err = 1'b0;
            p = (en === 1'b1) ? 1 : 0;
            l = (en === 1'b1) ? 1 : -1;
            for (int k = 2; k <= 20; k++) begin
                tick();
                if (en === 1'b1) begin
                    p++;
                    if (l < 0) l = k;
                end
            end
            cmp($sformatf("vec%0d_pulses", i), p, tbl[i].pulses);
            if (tbl[i].pulses == 1) cmp($sformatf("vec%0d_latency", i), l, c_LAT);
            cmp($sformatf("vec%0d_dir", i), {31'd0, up_down}, {31'd0, tbl[i].dir});
            cmp($sformatf("vec%0d_err", i), {31'd0, err},     {31'd0, tbl[i].err});
`ifdef QDEC_POS_EN
            cmp($sformatf("vec%0d_pos", i), {29'd0, pos},     {29'd0, tbl[i].pos});
`endif
        end

        // glitches: back to 00 (up, pos 2), then 1-cycle and 2-cycle pulses on A
        hold(2'b00, 20, p, l);
        cmp("to00_pulses", p, 1);
        hold(2'b10, 1, p, l);
        hold(2'b00, 12, p, l);
        cmp("glitch1_pulses", p, 0);
        hold(2'b10, 2, p, l);
        hold(2'b00, 12, p, l);
        cmp("glitch2_pulses", p, 0);
        cmp("glitch_err", {31'd0, err}, 32'd0);
`ifdef QDEC_POS_EN
        cmp("glitch_pos", {29'd0, pos}, 32'd2);
`endif

        // jump coinciding with i_clr_err: the set wins
        hold(2'b11, c_LAT - 1, p, l);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        cmp("jump_clr_err", {31'd0, err}, 32'd1);
        cmp("jump_clr_en",  {31'd0, en},  32'd0);
        hold(2'b11, 6, p, l);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        cmp("clr_err", {31'd0, err}, 32'd0);
        hold(2'b11, 6, p, l);

        // asynchronous reset mid-hold at AB=11
        #3 rst = 1'b1;
        model_reset();
        #1;
        cmp("async_rst_dir", {31'd0, up_down}, 32'd0);
        cmp("async_rst_en",  {31'd0, en},      32'd0);
`ifdef QDEC_POS_EN
        cmp("async_rst_pos", {29'd0, pos},     32'd0);
`endif
        tick();
        tick();
        rst = 1'b0;
        hold(2'b11, 20, p, l);
        cmp("rst_reprime_pulses", p, 0);
        hold(2'b10, 20, p, l);
        cmp("rst_step_pulses", p, 1);
        cmp("rst_step_dir", {31'd0, up_down}, 32'd1);
`ifdef QDEC_POS_EN
        cmp("rst_step_pos", {29'd0, pos}, 32'd1);
`endif

        // random phase walk, checked against the model every cycle
        for (int it = 0; it < 600; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 55) begin
                // legal single-phase step in a random direction
                if ($urandom_range(0, 1) == 1) begin
                    case ({a, b})
                        2'b00: {a, b} = 2'b01;
                        2'b01: {a, b} = 2'b11;
                        2'b11: {a, b} = 2'b10;
                        default: {a, b} = 2'b00;
                    endcase
                end else begin
                    case ({a, b})
                        2'b00: {a, b} = 2'b10;
                        2'b10: {a, b} = 2'b11;
                        2'b11: {a, b} = 2'b01;
                        default: {a, b} = 2'b00;
                    endcase
                end
            end else if (r < 97) begin
                {a, b} = 2'($urandom_range(0, 3));
            end else begin
                rst = 1'b1;
                tick();
                tick();
                rst = 1'b0;
            end
            clr_err = ($urandom_range(0, 7) == 0);
            for (int k = 0, n = $urandom_range(1, 8); k < n; k++) begin
                tick();
                clr_err = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_quad_step_decoder
`default_nettype wire
